// File: rtl/program_loader.sv
// Encodes field-level instruction descriptors into 32-bit ARM words and streams them into imem.
// Optional build macro PROGRAM_LOADER_CHECKSUM_EN adds an XOR checksum output of all written words.
module program_loader #(
  parameter int          ADDR_WIDTH = 6,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          MAX_WORDS  = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_cond,
  input  logic [1:0]            in_op,
  input  logic [5:0]            in_funct,
  input  logic [23:0]           in_operand,
  input  logic                  in_last,
  output logic                  imem_we,
  output logic [31:0]           imem_addr,
  output logic [31:0]           imem_wdata,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  busy,
  output logic                  done,
  output logic                  core_run,
  output logic                  error,
  output logic [1:0]            error_code
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]           checksum
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FLUSH = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH:0] ONE_W = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] MAX_W = (ADDR_WIDTH+1)'(MAX_WORDS);

  state_t                state_q, state_d;
  logic                  pend_q, pend_d;
  logic [31:0]           word_q, word_d;
  logic [ADDR_WIDTH:0]   index_q, index_d;
  logic                  ovf_q, ovf_d;
  logic [1:0]            code_q, code_d;
  logic                  hs_s;
  logic                  session_start_s;
  logic [ADDR_WIDTH:0]   accepted_num_s;

  function automatic logic [31:0] encode_word(
    input logic [3:0]  cond,
    input logic [1:0]  op,
    input logic [5:0]  funct,
    input logic [23:0] operand
  );
    logic [31:0] w;
    if (op == 2'b10) begin
      w = {cond, op, funct[5:4], operand};
    end else begin
      w = {cond, op, funct, operand[19:0]};
    end
    return w;
  endfunction

  assign hs_s            = in_valid & (state_q == S_LOAD);
  assign session_start_s = start & ((state_q == S_IDLE) | (state_q == S_DONE) | (state_q == S_ERROR));
  // Ordinal of a descriptor accepted now: already written plus the one still in flight, plus this one.
  assign accepted_num_s  = index_q + {{ADDR_WIDTH{1'b0}}, pend_q} + ONE_W;

  // Next-state, pending-write and index logic for the load session.
  always_comb begin
    state_d = state_q;
    pend_d  = 1'b0;
    word_d  = word_q;
    index_d = index_q;
    ovf_d   = ovf_q;
    code_d  = code_q;
    if (pend_q) begin
      index_d = index_q + ONE_W;
    end else begin
      index_d = index_q;
    end
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (session_start_s) begin
          state_d = S_LOAD;
          index_d = '0;
          ovf_d   = 1'b0;
          code_d  = 2'b00;
        end else begin
          state_d = state_q;
        end
      end
      S_LOAD: begin
        if (hs_s) begin
          if (in_op == 2'b11) begin
            state_d = S_ERROR;
            code_d  = 2'b01;
          end else begin
            pend_d = 1'b1;
            word_d = encode_word(in_cond, in_op, in_funct, in_operand);
            if (in_last) begin
              state_d = S_FLUSH;
            end else if (accepted_num_s == MAX_W) begin
              state_d = S_FLUSH;
              ovf_d   = 1'b1;
            end else begin
              state_d = S_LOAD;
            end
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_FLUSH: begin
        if (ovf_q) begin
          state_d = S_ERROR;
          code_d  = 2'b10;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Session state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pend_q  <= 1'b0;
      word_q  <= 32'h0000_0000;
      index_q <= '0;
      ovf_q   <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      word_q  <= word_d;
      index_q <= index_d;
      ovf_q   <= ovf_d;
      code_q  <= code_d;
    end
  end

  assign in_ready   = (state_q == S_LOAD);
  assign imem_we    = pend_q;
  assign imem_addr  = pend_q ? (BASE_ADDR + {{(32-ADDR_WIDTH-3){1'b0}}, index_q, 2'b00}) : 32'h0000_0000;
  assign imem_wdata = pend_q ? word_q : 32'h0000_0000;
  assign word_count = index_q;
  assign busy       = (state_q == S_LOAD) | (state_q == S_FLUSH);
  assign done       = (state_q == S_DONE);
  assign core_run   = (state_q == S_DONE);
  assign error      = (state_q == S_ERROR);
  assign error_code = code_q;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;

  // Running XOR of every word written this session.
  always_comb begin
    csum_d = csum_q;
    if (session_start_s) begin
      csum_d = 32'h0000_0000;
    end else if (pend_q) begin
      csum_d = csum_q ^ word_q;
    end else begin
      csum_d = csum_q;
    end
  end

  // Checksum register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      csum_q <= 32'h0000_0000;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed test-plan sessions plus randomized sessions
// checked cycle by cycle against a transaction-level reference model.
module tb_program_loader;

  localparam int          AW   = 3;
  localparam int          MAXW = 4;
  localparam logic [31:0] BASE = 32'h0000_0000;

  typedef struct packed {
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [23:0] operand;
    logic        last;
  } desc_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_cond = 4'h0;
  logic [1:0]    in_op = 2'b00;
  logic [5:0]    in_funct = 6'h00;
  logic [23:0]   in_operand = 24'h0;
  logic          in_last = 1'b0;
  logic          imem_we;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   word_count;
  logic          busy, done, core_run, error;
  logic [1:0]    error_code;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  program_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_cond(in_cond), .in_op(in_op), .in_funct(in_funct), .in_operand(in_operand),
    .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .word_count(word_count), .busy(busy), .done(done), .core_run(core_run), .error(error),
    .error_code(error_code)
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clock = ~clock;

  int errs = 0;
  int checks = 0;

  // Reference model: what the outside world should observe next cycle.
  bit          m_open, m_busy, m_done, m_err, m_we, m_term_done;
  logic [1:0]  m_code, m_term_code;
  int          m_wc, m_acc, m_countdown;
  logic [31:0] m_addr, m_data, m_csum;

  logic [31:0] seen_data[$];
  logic [31:0] seen_addr[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_word(input desc_t d);
    if (d.op == 2'd2)
      return (32'(d.cond) << 28) | (32'(d.op) << 26) | (32'(d.funct >> 4) << 24) | 32'(d.operand);
    return (32'(d.cond) << 28) | (32'(d.op) << 26) | (32'(d.funct) << 20) | (32'(d.operand) & 32'h000F_FFFF);
  endfunction

  function automatic desc_t rand_desc();
    desc_t d;
    d.cond    = 4'($urandom_range(0, 15));
    d.op      = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    d.funct   = 6'($urandom_range(0, 63));
    d.operand = 24'($urandom);
    d.last    = ($urandom_range(0, 3) == 0);
    return d;
  endfunction

  function automatic desc_t mk(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                               input logic [23:0] opnd, input logic l);
    desc_t d;
    d.cond = c; d.op = o; d.funct = f; d.operand = opnd; d.last = l;
    return d;
  endfunction

  task automatic model_reset();
    m_open = 0; m_busy = 0; m_done = 0; m_err = 0; m_we = 0; m_term_done = 0;
    m_code = 2'd0; m_term_code = 2'd0; m_wc = 0; m_acc = 0; m_countdown = 0;
    m_addr = 32'h0; m_data = 32'h0; m_csum = 32'h0;
  endtask

  // Called at a falling edge: check this cycle's outputs, drive next inputs, advance model.
  task automatic step(input bit s, input bit v, input desc_t d);
    bit was_busy, hs;
    desc_t junk;
    check_val("in_ready", 32'(in_ready), 32'(m_open));
    check_val("imem_we", 32'(imem_we), 32'(m_we));
    if (m_we) begin
      check_val("imem_addr", imem_addr, m_addr);
      check_val("imem_wdata", imem_wdata, m_data);
    end
    if (imem_we === 1'b1) begin
      seen_data.push_back(imem_wdata);
      seen_addr.push_back(imem_addr);
    end
    check_val("busy", 32'(busy), 32'(m_busy));
    check_val("done", 32'(done), 32'(m_done));
    check_val("core_run", 32'(core_run), 32'(m_done));
    check_val("error", 32'(error), 32'(m_err));
    check_val("error_code", 32'(error_code), 32'(m_code));
    check_val("word_count", 32'(word_count), 32'(m_wc));
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    check_val("checksum", checksum, m_csum);
`endif
    junk = rand_desc();
    if (!v) d = junk;
    start = s; in_valid = v;
    in_cond = d.cond; in_op = d.op; in_funct = d.funct; in_operand = d.operand; in_last = d.last;

    was_busy = m_busy;
    hs = v && m_open;
    if (m_we) begin
      m_wc++;
      m_csum ^= m_data;
    end
    m_we = 0;
    if (m_countdown > 0) begin
      m_countdown--;
      if (m_countdown == 0) begin
        m_busy = 0;
        if (m_term_done) m_done = 1;
        else begin m_err = 1; m_code = m_term_code; end
      end
    end
    if (s && !was_busy) begin
      m_busy = 1; m_open = 1; m_done = 0; m_err = 0; m_code = 2'd0;
      m_wc = 0; m_csum = 32'h0; m_acc = 0;
    end else if (hs) begin
      m_acc++;
      if (d.op == 2'd3) begin
        m_open = 0; m_busy = 0; m_err = 1; m_code = 2'd1;
      end else begin
        m_we = 1;
        m_addr = BASE + 32'(4 * (m_acc - 1));
        m_data = model_word(d);
        if (d.last) begin
          m_open = 0; m_countdown = 1; m_term_done = 1;
        end else if (m_acc == MAXW) begin
          m_open = 0; m_countdown = 1; m_term_done = 0; m_term_code = 2'd2;
        end
      end
    end
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, rand_desc());
  endtask

  task automatic run_random_session();
    desc_t d;
    int n;
    bit v, s, hs_now;
    d = rand_desc();
    step(1'b1, 1'($urandom_range(0, 1)), d);
    n = 0;
    while (m_busy && n < 100) begin
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 15) == 0);
      hs_now = v && m_open;
      step(s, v, d);
      if (hs_now) d = rand_desc();
      n++;
    end
    for (int i = 0; i < 2; i++) step(1'b0, 1'($urandom_range(0, 1)), rand_desc());
  endtask

  desc_t d_add, d_ldr, d_b, d_add_last, d_ill;

  initial begin
    d_add      = mk(4'hE, 2'b00, 6'b001000, 24'h002001, 1'b0);
    d_add_last = mk(4'hE, 2'b00, 6'b001000, 24'h002001, 1'b1);
    d_ldr      = mk(4'hE, 2'b01, 6'b011001, 24'h002004, 1'b0);
    d_b        = mk(4'hE, 2'b10, 6'b100000, 24'hFFFFFE, 1'b1);
    d_ill      = mk(4'hE, 2'b11, 6'b000000, 24'h000000, 1'b0);
    model_reset();
    @(negedge clock);
    idle(2);
    reset = 1'b1;
    step(1'b0, 1'b1, d_add);
    idle(1);

    // Single DP word
    seen_data.delete(); seen_addr.delete();
    step(1'b1, 1'b0, d_add);
    step(1'b0, 1'b1, d_add_last);
    idle(3);
    check_val("single_count", 32'(seen_data.size()), 32'd1);
    check_val("single_data", seen_data[0], 32'hE080_2001);
    check_val("single_addr", seen_addr[0], 32'h0000_0000);
    check_val("single_wc", 32'(word_count), 32'd1);
    check_val("single_done", 32'(done & core_run), 32'd1);

    // Restart from DONE, then three back-to-back words
    seen_data.delete(); seen_addr.delete();
    step(1'b1, 1'b0, d_add);
    check_val("restart_done", 32'(done | core_run), 32'd0);
    check_val("restart_wc", 32'(word_count), 32'd0);
    step(1'b0, 1'b1, d_add);
    step(1'b0, 1'b1, d_ldr);
    step(1'b0, 1'b1, d_b);
    idle(3);
    check_val("b2b_count", 32'(seen_data.size()), 32'd3);
    check_val("b2b_w0", seen_data[0], 32'hE080_2001);
    check_val("b2b_w1", seen_data[1], 32'hE590_2004);
    check_val("b2b_w2", seen_data[2], 32'hEAFF_FFFE);
    check_val("b2b_a2", seen_addr[2], 32'h0000_0008);
    check_val("b2b_wc", 32'(word_count), 32'd3);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    check_val("b2b_csum", checksum, 32'hE080_2001 ^ 32'hE590_2004 ^ 32'hEAFF_FFFE);
`endif

    // Illegal op on the second descriptor
    seen_data.delete(); seen_addr.delete();
    step(1'b1, 1'b0, d_add);
    step(1'b0, 1'b1, d_add);
    step(1'b0, 1'b1, d_ill);
    step(1'b0, 1'b1, d_ldr);
    idle(2);
    check_val("ill_count", 32'(seen_data.size()), 32'd1);
    check_val("ill_error", 32'(error), 32'd1);
    check_val("ill_code", 32'(error_code), 32'd1);
    check_val("ill_ready", 32'(in_ready), 32'd0);
    check_val("ill_run", 32'(core_run), 32'd0);

    // Overflow: MAXW descriptors without last
    seen_data.delete(); seen_addr.delete();
    step(1'b1, 1'b0, d_add);
    for (int i = 0; i < MAXW; i++) step(1'b0, 1'b1, d_ldr);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, d_add);
    check_val("ovf_count", 32'(seen_data.size()), 32'(MAXW));
    check_val("ovf_last_addr", seen_addr[MAXW-1], 32'h0000_000C);
    check_val("ovf_code", 32'(error_code), 32'd2);

    // Exactly MAXW words with last on the final one completes normally
    step(1'b1, 1'b0, d_add);
    for (int i = 0; i < MAXW - 1; i++) step(1'b0, 1'b1, d_ldr);
    step(1'b0, 1'b1, d_b);
    idle(3);
    check_val("full_done", 32'(done), 32'd1);

    // Reset asserted in the cycle after a handshake
    step(1'b1, 1'b0, d_add);
    start = 1'b0; in_valid = 1'b1;
    in_cond = d_add.cond; in_op = d_add.op; in_funct = d_add.funct;
    in_operand = d_add.operand; in_last = d_add.last;
    @(posedge clock);
    #1 reset = 1'b0;
    in_valid = 1'b0;
    #1;
    check_val("rst_we", 32'(imem_we), 32'd0);
    check_val("rst_addr", imem_addr, 32'h0);
    check_val("rst_data", imem_wdata, 32'h0);
    check_val("rst_flags", {26'd0, in_ready, busy, done, core_run, error, 1'b0}, 32'h0);
    check_val("rst_code", 32'(error_code), 32'd0);
    check_val("rst_wc", 32'(word_count), 32'd0);
    model_reset();
    seen_data.delete(); seen_addr.delete();
    @(negedge clock);
    step(1'b0, 1'b1, d_add);
    step(1'b0, 1'b1, d_add);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, d_add);
    check_val("rst_no_write", 32'(seen_data.size()), 32'd0);

    // Randomized sessions
    for (int k = 0; k < 40; k++) run_random_session();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
